// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: round-robin share of one DDR2 command port between Icache and Dcache.
// Optional busy-timeout abort with sticky error is built when MEM_ARB_TIMEOUT_EN is defined.
module ddr_port_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 256,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_valid,
  input  logic              dc_valid,
  input  logic              ic_rw,
  input  logic              dc_rw,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] ic_data_wr,
  input  logic [DATA_W-1:0] dc_data_wr,
  output logic [DATA_W-1:0] ic_data_rd,
  output logic [DATA_W-1:0] dc_data_rd,
  output logic              ic_ready,
  output logic              dc_ready,
  output logic              mem_valid,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_wr,
  input  logic [DATA_W-1:0] mem_data_rd,
  input  logic              mem_ready,
  output logic              owner,
  output logic              error
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, owner_q, owner_d, rw_q, rw_d, grant_dc, timeout;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, ic_rd_q, ic_rd_d, dc_rd_q, dc_rd_d;
  // Dcache wins when alone, or on a tie when Icache was granted last.
  assign grant_dc = dc_valid & (~ic_valid | ~last_q);
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic err_q;
  assign cnt_d = (state_q == BUSY) ? cnt_q + 1'b1 : '0;
  assign timeout = (state_q == BUSY) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
  assign error = err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | (timeout & ~mem_ready);
    end
  end
`else
  assign timeout = 1'b0;
  assign error = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ic_rd_d = ic_rd_q;
    dc_rd_d = dc_rd_q;
    case (state_q)
      IDLE: if (ic_valid | dc_valid) begin
        state_d = BUSY;
        owner_d = grant_dc;
        last_d  = grant_dc;
        rw_d    = grant_dc ? dc_rw : ic_rw;
        addr_d  = grant_dc ? dc_addr : ic_addr;
        wdata_d = grant_dc ? dc_data_wr : ic_data_wr;
      end
      BUSY: if (mem_ready) begin
        state_d = RESP;
        ic_rd_d = (!rw_q && !owner_q) ? mem_data_rd : ic_rd_q;
        dc_rd_d = (!rw_q && owner_q) ? mem_data_rd : dc_rd_q;
      end else if (timeout) begin
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ic_rd_q <= '0;
      dc_rd_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ic_rd_q <= ic_rd_d;
      dc_rd_q <= dc_rd_d;
    end
  end
  assign mem_valid   = (state_q == BUSY);
  assign ic_ready    = (state_q == RESP) & ~owner_q;
  assign dc_ready    = (state_q == RESP) & owner_q;
  assign mem_rw      = rw_q;
  assign mem_addr    = addr_q;
  assign mem_data_wr = wdata_q;
  assign owner       = owner_q;
  assign ic_data_rd  = ic_rd_q;
  assign dc_data_rd  = dc_rd_q;
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: randomized and directed checks of ddr_port_arbiter against a transaction-level model.
// Define MEM_ARB_TIMEOUT_EN to also exercise the timeout abort with TIMEOUT_CYCLES = 8.
module tb_ddr_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 256;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1023;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic rv[2] = '{1'b0, 1'b0};
  logic rrw[2] = '{1'b0, 1'b0};
  logic [AW-1:0] ra[2] = '{'0, '0};
  logic [DW-1:0] rwd[2] = '{'0, '0};
  logic mem_ready = 1'b0;
  logic [DW-1:0] mem_data_rd = '0;
  logic [DW-1:0] ic_data_rd, dc_data_rd, mem_data_wr;
  logic [AW-1:0] mem_addr;
  logic ic_ready, dc_ready, mem_valid, mem_rw, owner, error;

  ddr_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ic_valid(rv[0]), .dc_valid(rv[1]), .ic_rw(rrw[0]), .dc_rw(rrw[1]),
    .ic_addr(ra[0]), .dc_addr(ra[1]), .ic_data_wr(rwd[0]), .dc_data_wr(rwd[1]),
    .ic_data_rd(ic_data_rd), .dc_data_rd(dc_data_rd), .ic_ready(ic_ready), .dc_ready(dc_ready),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_data_wr(mem_data_wr),
    .mem_data_rd(mem_data_rd), .mem_ready(mem_ready), .owner(owner), .error(error)
  );

  int n_cmp = 0, n_err = 0;
  int phase = 0, lat_cnt = 0, lat_cfg = 0, req_mode = 0, busy_cnt = 0;
  int done_cnt[2] = '{0, 0};
  bit noise = 0, use_fixed = 0, last_m = 1, owner_m = 0, cur_rw = 0, exp_err = 0, prev_mv = 0;
  bit pend[2] = '{0, 0};
  bit got_ready[2] = '{0, 0};
  bit own_log[$];
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_wd = '0, fixed_val = '0, last_fire = '0;
  logic [DW-1:0] exp_rd[2] = '{'0, '0};

  function automatic logic [DW-1:0] rand_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic post(input int p, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rv[p] = 1'b1; rrw[p] = rw; ra[p] = a; rwd[p] = d; pend[p] = 1'b1;
  endtask

  task automatic new_cmd(input int p);
    post(p, 1'($urandom_range(0, 1)), AW'($urandom), rand_line());
  endtask

  task automatic model_reset();
    phase = 0; last_m = 1; owner_m = 0; exp_err = 0; busy_cnt = 0; prev_mv = 0;
    exp_rd[0] = '0; exp_rd[1] = '0; mem_ready = 1'b0;
  endtask

  // One clock: check what the DUT did at the last rising edge, then drive requesters and memory.
  task automatic cycle();
    int w;
    bit to_hit;
    @(negedge clk);
    got_ready[0] = 0; got_ready[1] = 0; to_hit = 0;
    if (mem_valid === 1'b1 && !prev_mv) own_log.push_back(owner);
    prev_mv = (mem_valid === 1'b1);
    if (phase == 0) begin
      if (rv[0] || rv[1]) begin
        w = (rv[0] && rv[1]) ? int'(!last_m) : (rv[1] ? 1 : 0);
        n_cmp++;
        if (!pend[w]) begin n_err++; $display("FAIL reissue: port %0d granted a command already served", w); end
        n_cmp++;
        if (mem_valid !== 1'b1 || owner !== w[0]) begin
          n_err++; $display("FAIL grant: mem_valid=%b owner=%b, want 1 and %0d", mem_valid, owner, w);
        end
        n_cmp++;
        if (mem_rw !== rrw[w] || mem_addr !== ra[w] || mem_data_wr !== rwd[w]) begin
          n_err++; $display("FAIL issue_cmd: rw=%b addr=%h wd=%h, want rw=%b addr=%h wd=%h", mem_rw, mem_addr, mem_data_wr, rrw[w], ra[w], rwd[w]);
        end
        pend[w] = 0; last_m = w[0]; owner_m = w[0]; cur_rw = rrw[w]; cur_addr = ra[w]; cur_wd = rwd[w];
        phase = 1; busy_cnt = 0;
        lat_cnt = (lat_cfg < 0) ? $urandom_range(0, 5) : lat_cfg;
      end else begin
        n_cmp++;
        if (mem_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: mem_valid=%b, want 0", mem_valid); end
      end
    end else if (phase == 1) begin
      busy_cnt++;
`ifdef MEM_ARB_TIMEOUT_EN
      to_hit = !mem_ready && busy_cnt == TO;
`endif
      if (mem_ready || to_hit) begin
        if (to_hit) exp_err = 1;
        else if (!cur_rw) exp_rd[owner_m] = mem_data_rd;
        got_ready[owner_m] = 1; phase = 2;
        n_cmp++;
        if (mem_valid !== 1'b0) begin n_err++; $display("FAIL done_valid: mem_valid=%b, want 0", mem_valid); end
      end else begin
        n_cmp++;
        if (mem_valid !== 1'b1 || mem_rw !== cur_rw || mem_addr !== cur_addr || mem_data_wr !== cur_wd) begin
          n_err++; $display("FAIL busy_hold: valid=%b rw=%b addr=%h, want 1 rw=%b addr=%h", mem_valid, mem_rw, mem_addr, cur_rw, cur_addr);
        end
      end
    end else begin
      phase = 0;
      n_cmp++;
      if (mem_valid !== 1'b0) begin n_err++; $display("FAIL resp_valid: mem_valid=%b, want 0", mem_valid); end
    end
    n_cmp++;
    if (ic_ready !== got_ready[0] || dc_ready !== got_ready[1]) begin
      n_err++; $display("FAIL ready: ic=%b dc=%b, want ic=%b dc=%b", ic_ready, dc_ready, got_ready[0], got_ready[1]);
    end
    n_cmp++;
    if (ic_data_rd !== exp_rd[0] || dc_data_rd !== exp_rd[1]) begin
      n_err++; $display("FAIL data_rd: ic=%h dc=%h, want ic=%h dc=%h", ic_data_rd, dc_data_rd, exp_rd[0], exp_rd[1]);
    end
    n_cmp++;
    if (owner !== owner_m || error !== exp_err) begin
      n_err++; $display("FAIL owner_error: owner=%b error=%b, want %b %b", owner, error, owner_m, exp_err);
    end
    for (int p = 0; p < 2; p++) begin
      if (got_ready[p]) begin
        done_cnt[p]++;
        if (req_mode == 1 || (req_mode == 2 && $urandom_range(0, 1) == 1)) new_cmd(p);
        else rv[p] = 1'b0;
      end else if (req_mode == 2 && !rv[p] && $urandom_range(0, 2) == 0) new_cmd(p);
    end
    mem_data_rd = rand_line();
    if (phase == 1) begin
      if (lat_cnt == 0) begin
        mem_ready = 1'b1;
        if (use_fixed) mem_data_rd = fixed_val;
        last_fire = mem_data_rd;
      end else begin
        lat_cnt--; mem_ready = 1'b0;
      end
    end else mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  task automatic run_until(input int p, input int bound, output int n);
    n = 0;
    for (int i = 1; i <= bound && n == 0; i++) begin
      cycle();
      if (got_ready[p]) n = i;
    end
  endtask

  task automatic drain();
    int i;
    req_mode = 0; noise = 0;
    for (i = 0; i < 100 && !(phase == 0 && !rv[0] && !rv[1]); i++) cycle();
    n_cmp++;
    if (i == 100) begin n_err++; $display("FAIL drain: still busy after %0d cycles, want idle", i); end
  endtask

  task automatic do_reset();
    rst = 1'b1; rv[0] = 0; rv[1] = 0; pend[0] = 0; pend[1] = 0;
    req_mode = 0; noise = 0; use_fixed = 0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({mem_valid, mem_rw, ic_ready, dc_ready, owner, error} !== 6'b0) begin
      n_err++; $display("FAIL reset_ctl: valid,rw,icr,dcr,owner,err=%b, want 000000", {mem_valid, mem_rw, ic_ready, dc_ready, owner, error});
    end
    n_cmp++;
    if (mem_addr !== '0 || mem_data_wr !== '0 || ic_data_rd !== '0 || dc_data_rd !== '0) begin
      n_err++; $display("FAIL reset_data: addr=%h wd=%h ic=%h dc=%h, want all 0", mem_addr, mem_data_wr, ic_data_rd, dc_data_rd);
    end
    do_reset();
    repeat (2) cycle();
  endtask

  task automatic test_ic_read();
    int vcnt = 0, icp = 0, dcp = 0, at = 0;
    fixed_val = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    use_fixed = 1; lat_cfg = 4;
    post(0, 1'b0, 28'h0000008, rand_line());
    for (int i = 1; i <= 12; i++) begin
      cycle();
      vcnt += int'(mem_valid); icp += int'(ic_ready); dcp += int'(dc_ready);
      if (ic_ready === 1'b1 && at == 0) at = i;
    end
    use_fixed = 0;
    n_cmp++;
    if (vcnt != 5 || at != 6) begin n_err++; $display("FAIL ic_read_timing: valid_cycles=%0d ready_at=%0d, want 5 and 6", vcnt, at); end
    n_cmp++;
    if (icp != 1 || dcp != 0) begin n_err++; $display("FAIL ic_read_pulses: ic=%0d dc=%0d, want 1 and 0", icp, dcp); end
    n_cmp++;
    if (ic_data_rd !== fixed_val) begin n_err++; $display("FAIL ic_read_data: %h, want %h", ic_data_rd, fixed_val); end
  endtask

  task automatic test_tie_from_reset();
    int gap = -1, low = 0;
    bit seen = 0;
    do_reset();
    lat_cfg = 1; own_log.delete();
    post(0, 1'b1, 28'h1000008, rand_line());
    post(1, 1'b0, 28'h2000030, rand_line());
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (mem_valid === 1'b1) begin
        if (seen && low > 0) gap = low;
        low = 0; seen = 1;
      end else if (seen) low++;
    end
    n_cmp++;
    if (own_log.size() != 2 || own_log[0] !== 1'b0 || own_log[1] !== 1'b1) begin
      n_err++; $display("FAIL tie_order: %0d grants, first owners %b %b, want 2 grants 0 then 1",
                        own_log.size(), own_log.size() > 0 ? own_log[0] : 1'bx, own_log.size() > 1 ? own_log[1] : 1'bx);
    end
    n_cmp++;
    if (gap != 2) begin n_err++; $display("FAIL tie_gap: mem_valid low %0d cycles between commands, want 2", gap); end
  endtask

  task automatic test_alternate();
    int i;
    own_log.delete(); req_mode = 1; lat_cfg = -1;
    new_cmd(0); new_cmd(1);
    for (i = 0; i < 200 && own_log.size() < 6; i++) cycle();
    drain();
    n_cmp++;
    if (own_log.size() < 6) begin n_err++; $display("FAIL alt_count: %0d grants, want at least 6", own_log.size()); end
    for (int k = 0; k < 6 && k < own_log.size(); k++) begin
      n_cmp++;
      if (own_log[k] !== 1'(k % 2)) begin n_err++; $display("FAIL alt_order: grant %0d owner %b, want %0d", k, own_log[k], k % 2); end
    end
  endtask

  task automatic test_dc_write_read();
    int n;
    logic [AW-1:0] a;
    logic [DW-1:0] prev;
    a = AW'($urandom); prev = exp_rd[1]; lat_cfg = 2;
    post(1, 1'b1, a, rand_line());
    run_until(1, 20, n);
    n_cmp++;
    if (n == 0 || dc_data_rd !== prev) begin n_err++; $display("FAIL dc_write_hold: ready_at=%0d data=%h, want ready and %h", n, dc_data_rd, prev); end
    cycle();
    post(1, 1'b0, a, rand_line());
    run_until(1, 20, n);
    n_cmp++;
    if (n == 0 || dc_data_rd !== last_fire) begin n_err++; $display("FAIL dc_read_data: ready_at=%0d data=%h, want ready and %h", n, dc_data_rd, last_fire); end
    drain();
  endtask

  task automatic test_reset_busy();
    int n, i;
    lat_cfg = 10;
    post(0, 1'b0, AW'($urandom), rand_line());
    for (i = 0; i < 5 && mem_valid !== 1'b1; i++) cycle();
    repeat (2) cycle();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (mem_valid !== 1'b0 || ic_ready !== 1'b0 || dc_ready !== 1'b0) begin
      n_err++; $display("FAIL async_abort: valid=%b icr=%b dcr=%b, want 000", mem_valid, ic_ready, dc_ready);
    end
    model_reset(); pend[0] = 1; lat_cfg = 2; own_log.delete();
    @(negedge clk);
    rst = 1'b0;
    run_until(0, 20, n);
    n_cmp++;
    if (n == 0 || own_log.size() != 1 || own_log[0] !== 1'b0) begin
      n_err++; $display("FAIL rearbitrate: ready_at=%0d grants=%0d, want ready after 1 Icache grant", n, own_log.size());
    end
    drain();
  endtask

  task automatic test_random();
    int d0, d1;
    d0 = done_cnt[0]; d1 = done_cnt[1];
    req_mode = 2; noise = 1; lat_cfg = -1;
    repeat (400) cycle();
    drain();
    n_cmp++;
    if (done_cnt[0] == d0 || done_cnt[1] == d1) begin
      n_err++; $display("FAIL random_progress: ic done %0d dc done %0d, want both > 0", done_cnt[0] - d0, done_cnt[1] - d1);
    end
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int vcnt = 0, at = 0;
    do_reset();
    lat_cfg = 1000;
    post(0, 1'b0, AW'($urandom), rand_line());
    for (int i = 1; i <= 20 && at == 0; i++) begin
      cycle();
      vcnt += int'(mem_valid);
      if (ic_ready === 1'b1) at = i;
    end
    n_cmp++;
    if (at == 0 || vcnt != 8 || error !== 1'b1) begin
      n_err++; $display("FAIL timeout: ready_at=%0d busy=%0d error=%b, want ready busy 8 error 1", at, vcnt, error);
    end
    repeat (5) cycle();
    n_cmp++;
    if (error !== 1'b1) begin n_err++; $display("FAIL timeout_sticky: error=%b, want 1", error); end
    do_reset();
    #1;
    n_cmp++;
    if (error !== 1'b0) begin n_err++; $display("FAIL timeout_clear: error=%b, want 0", error); end
  endtask
`endif

  initial begin
    test_reset();
    test_ic_read();
    test_tie_from_reset();
    test_alternate();
    test_dc_write_read();
    test_reset_busy();
    test_random();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end
endmodule
